mdl_bdy_xbar: RTL and testbench
===============================

MDL_BDY_XBAR -- requirements
Module: MDL_BDY_XBAR

Interface
REQ-001 SHALL have parameter PRM_DAXI, default 64, stream data width.
REQ-002 SHALL have parameter PRM_NENG, default 4, number of attached compute engines (2..8).
REQ-003 SHALL have parameter PRM_SELW, default 2, engine-select width (≥ clog2(PRM_NENG)).
REQ-004 SHALL have parameter PRM_TOUT, default 1024, watchdog limit in idle RUN cycles.
REQ-005 iSYS_CLK  in  1  sole clock; all logic on its rising edge.
REQ-006 iSYS_RST  in  1  reset, synchronous, active-low.
REQ-007 iCTL_CMD_VALID  in  1  one-cycle command strobe; iCTL_SEL  in  PRM_SELW  target engine index.
REQ-008 oCTL_BUSY  out  1  high from command accept to DONE; oCTL_DONE  out  1  one-cycle completion pulse; oCTL_ERR  out  1  one-cycle error pulse.
REQ-009 oCTL_INBEATS, oCTL_OUTBEATS  out  16 each  beat counters of the current/last job.
REQ-010 iRm_Tvalid in 1, oRm_Tready out 1, iRm_Tdata in PRM_DAXI, iRm_Tlast in 1: ingress stream from read FIFO.
REQ-011 oENG_START out PRM_NENG, iENG_DONE in PRM_NENG: per-engine start pulse / done level-or-pulse.
REQ-012 oEs_Tvalid out PRM_NENG, iEs_Tready in PRM_NENG, oEs_Tdata out PRM_DAXI (shared), oEs_Tlast out 1 (shared): engine ingress.
REQ-013 iEm_Tvalid in PRM_NENG, oEm_Tready out PRM_NENG, iEm_Tdata in PRM_NENG*PRM_DAXI (engine k at [k*PRM_DAXI +: PRM_DAXI]), iEm_Tlast in PRM_NENG: engine egress.
REQ-014 oWs_Tvalid out 1, iWs_Tready in 1, oWs_Tdata out PRM_DAXI, oWs_Tlast out 1: egress to write FIFO.

Function
REQ-015 FSM states IDLE, START, RUN, DONE; reset state IDLE.
REQ-016 IDLE: iCTL_CMD_VALID with iCTL_SEL < PRM_NENG -> latch sel, clear both beat counters and in_last/out_last/eng_done flags, go START.
REQ-017 IDLE: iCTL_CMD_VALID with iCTL_SEL ≥ PRM_NENG -> oCTL_ERR pulse next cycle, remain IDLE.
REQ-018 iCTL_CMD_VALID outside IDLE SHALL be ignored, no error.
REQ-019 START: oENG_START[sel]=1 for exactly one cycle, then RUN; all other oENG_START bits always 0.
REQ-020 RUN ingress, zero latency: oEs_Tvalid[sel] = iRm_Tvalid & ~in_last; oRm_Tready = iEs_Tready[sel] & ~in_last; oEs_Tdata/oEs_Tlast = iRm_Tdata/iRm_Tlast.
REQ-021 Ingress handshake with iRm_Tlast=1 sets in_last; further ingress blocked until next job.
REQ-022 Egress through 2-entry registered skid FIFO: oEm_Tready[sel] = (occupancy < 2); oWs_Tvalid = (occupancy ≠ 0); 1-cycle latency engine handshake -> oWs_Tvalid.
REQ-023 Simultaneous push and pop SHALL leave occupancy unchanged; data order preserved.
REQ-024 Non-selected engines and all engines outside RUN: oEs_Tvalid=0, oEm_Tready=0.
REQ-025 Egress pop with oWs_Tlast=1 sets out_last; iENG_DONE[sel]=1 in RUN sets eng_done (sticky).
REQ-026 RUN -> DONE when eng_done & out_last & skid empty, evaluated on registered flags; same-cycle done and last accepted.
REQ-027 DONE: oCTL_DONE=1 one cycle, then IDLE; counters hold until next accepted command.
REQ-028 Beat counters increment per handshake (ingress/egress pop), 16-bit, saturating at 16'hFFFF.
REQ-029 Watchdog: counter clears on any ingress/egress handshake or iENG_DONE; reaching PRM_TOUT in RUN -> oCTL_ERR pulse, skid flushed, IDLE, no oCTL_DONE.
REQ-030 oCTL_BUSY = (state ≠ IDLE).

Reset
REQ-031 iSYS_RST=0 at a clock edge SHALL force IDLE, skid empty, flags/watchdog/counters 0, regardless of state.
REQ-032 During and after reset until a command: oRm_Tready, oENG_START, oEs_Tvalid, oEm_Tready, oWs_Tvalid, oWs_Tlast, oCTL_BUSY, oCTL_DONE, oCTL_ERR all 0; oCTL_INBEATS/OUTBEATS 0.
REQ-033 Reset mid-RUN SHALL drop skid contents; no oCTL_DONE or oCTL_ERR for the aborted job.

Verification
REQ-034 Cmd sel=2, 8 ingress beats (last on 8th), engine 2 returns 8 beats then done -> one oENG_START[2] pulse, oCTL_DONE once, INBEATS=8, OUTBEATS=8, data in order.
REQ-035 Cmd sel=5 with PRM_NENG=4 -> oCTL_ERR one cycle, oCTL_BUSY stays 0.
REQ-036 iWs_Tready=0 for 10 cycles during egress -> occupancy 2, oEm_Tready[sel]=0, no beat lost or duplicated after release.
REQ-037 Engine stalls (no handshakes, no done), PRM_TOUT=16 -> oCTL_ERR exactly 16 cycles after last activity, state IDLE.
REQ-038 iSYS_RST=0 mid-RUN with 1 beat in skid -> next cycle all outputs per REQ-032; new cmd afterwards completes normally.
REQ-039 iENG_DONE asserted before final egress tlast -> oCTL_DONE only after tlast beat popped and skid empty.

Source files
------------

// File: rtl/mdl_bdy_xbar.sv
`default_nettype none
// ============================================================================
// Module   : mdl_bdy_xbar
// Purpose  : Job-level crossbar between one read stream, a bank of compute
//            engines and one write stream. A command selects one engine. The
//            engine is started, ingress beats pass straight through to it, and
//            its egress beats drain through a 2-entry skid FIFO. Completion
//            needs the engine done flag plus the final egress beat. A watchdog
//            aborts jobs that make no progress.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   iSYS_CLK / iSYS_RST        clock, synchronous active-low reset
//   iCTL_CMD_VALID, iCTL_SEL   command strobe and target engine index
//   oCTL_BUSY/DONE/ERR         job status, done and error pulses
//   oCTL_INBEATS/OUTBEATS      beat counts of the current or last job
//   iRm_* / oRm_Tready         ingress stream from the read FIFO
//   oENG_START, iENG_DONE      per-engine start pulse and done indication
//   oEs_*, iEs_Tready          engine ingress (data and last are shared)
//   iEm_*, oEm_Tready          engine egress (data packed per engine)
//   oWs_*, iWs_Tready          egress stream to the write FIFO
// ============================================================================
module mdl_bdy_xbar #(
  parameter int PRM_DAXI = 64,
  parameter int PRM_NENG = 4,
  parameter int PRM_SELW = 2,
  parameter int PRM_TOUT = 1024
) (
  input  logic                         iSYS_CLK,
  input  logic                         iSYS_RST,
  input  logic                         iCTL_CMD_VALID,
  input  logic [PRM_SELW-1:0]          iCTL_SEL,
  output logic                         oCTL_BUSY,
  output logic                         oCTL_DONE,
  output logic                         oCTL_ERR,
  output logic [15:0]                  oCTL_INBEATS,
  output logic [15:0]                  oCTL_OUTBEATS,
  input  logic                         iRm_Tvalid,
  output logic                         oRm_Tready,
  input  logic [PRM_DAXI-1:0]          iRm_Tdata,
  input  logic                         iRm_Tlast,
  output logic [PRM_NENG-1:0]          oENG_START,
  input  logic [PRM_NENG-1:0]          iENG_DONE,
  output logic [PRM_NENG-1:0]          oEs_Tvalid,
  input  logic [PRM_NENG-1:0]          iEs_Tready,
  output logic [PRM_DAXI-1:0]          oEs_Tdata,
  output logic                         oEs_Tlast,
  input  logic [PRM_NENG-1:0]          iEm_Tvalid,
  output logic [PRM_NENG-1:0]          oEm_Tready,
  input  logic [PRM_NENG*PRM_DAXI-1:0] iEm_Tdata,
  input  logic [PRM_NENG-1:0]          iEm_Tlast,
  output logic                         oWs_Tvalid,
  input  logic                         iWs_Tready,
  output logic [PRM_DAXI-1:0]          oWs_Tdata,
  output logic                         oWs_Tlast
);

  localparam int                WDW    = $clog2(PRM_TOUT + 1);
  localparam logic [PRM_SELW:0] NENG_W = (PRM_SELW + 1)'(PRM_NENG);
  localparam logic [WDW-1:0]    WD_MAX = WDW'(PRM_TOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                state, state_nxt;
  logic [PRM_SELW-1:0]   sel;
  logic [PRM_NENG-1:0]   sel_oh;
  logic                  in_last, out_last, eng_done, err_q;
  logic [15:0]           in_beats, out_beats;
  logic [WDW-1:0]        wd;
  logic [1:0]            cnt;
  logic                  wr_ptr, rd_ptr;
  logic [PRM_DAXI-1:0]   skid_data [2];
  logic [1:0]            skid_last;
  logic [PRM_DAXI-1:0]   em_data;
  logic                  em_last, em_vld, es_rdy, sel_done;
  logic                  run, cmd_ok, cmd_acc, cmd_bad;
  logic                  in_hs, em_rdy, push, pop, activity, wd_hit, job_end;

  // One-hot decode of the latched engine index; all per-engine muxing uses it
  // so the index width never has to match the engine vector width.
  for (genvar k = 0; k < PRM_NENG; k++) begin : g_eng
    assign sel_oh[k]     = (sel == PRM_SELW'(k));
    assign oENG_START[k] = (state == ST_START) & sel_oh[k];
    assign oEs_Tvalid[k] = run & sel_oh[k] & iRm_Tvalid & ~in_last;
    assign oEm_Tready[k] = em_rdy & sel_oh[k];
  end

  always_comb begin
    em_data = '0;
    for (int k = 0; k < PRM_NENG; k++) begin
      if (sel_oh[k]) em_data = iEm_Tdata[k*PRM_DAXI +: PRM_DAXI];
    end
  end

  assign em_last  = |(iEm_Tlast  & sel_oh);
  assign em_vld   = |(iEm_Tvalid & sel_oh);
  assign es_rdy   = |(iEs_Tready & sel_oh);
  assign sel_done = |(iENG_DONE  & sel_oh);

  assign run      = (state == ST_RUN);
  assign cmd_ok   = ({1'b0, iCTL_SEL} < NENG_W);
  assign cmd_acc  = (state == ST_IDLE) & iCTL_CMD_VALID & cmd_ok;
  assign cmd_bad  = (state == ST_IDLE) & iCTL_CMD_VALID & ~cmd_ok;

  // Ingress is a pure combinational pass-through once the job is running.
  assign oRm_Tready = run & es_rdy & ~in_last;
  assign oEs_Tdata  = iRm_Tdata;
  assign oEs_Tlast  = iRm_Tlast;
  assign in_hs      = oRm_Tready & iRm_Tvalid;

  // Egress skid: ready depends only on occupancy, so a full FIFO with a
  // stalled write side pushes back on the engine without losing a beat.
  assign em_rdy     = run & (cnt != 2'd2);
  assign push       = em_rdy & em_vld;
  assign oWs_Tvalid = (cnt != 2'd0);
  assign oWs_Tdata  = skid_data[rd_ptr];
  assign oWs_Tlast  = skid_last[rd_ptr] & oWs_Tvalid;
  assign pop        = oWs_Tvalid & iWs_Tready;

  assign activity = in_hs | push | pop | (run & sel_done);
  assign wd_hit   = run & ~activity & (wd == WD_MAX);
  // Flags are registered, so a done and last beat arriving together complete
  // the job one cycle later.
  assign job_end  = run & eng_done & out_last & (cnt == 2'd0);

  assign oCTL_BUSY     = (state != ST_IDLE);
  assign oCTL_DONE     = (state == ST_DONE);
  assign oCTL_ERR      = err_q;
  assign oCTL_INBEATS  = in_beats;
  assign oCTL_OUTBEATS = out_beats;

  always_ff @(posedge iSYS_CLK) begin
    if (!iSYS_RST) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (cmd_acc) state_nxt = ST_START;
      ST_START: state_nxt = ST_RUN;
      ST_RUN: begin
        if (job_end)     state_nxt = ST_DONE;
        else if (wd_hit) state_nxt = ST_IDLE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iSYS_CLK) begin
    if (!iSYS_RST) begin
      sel       <= '0;
      in_last   <= 1'b0;
      out_last  <= 1'b0;
      eng_done  <= 1'b0;
      err_q     <= 1'b0;
      in_beats  <= '0;
      out_beats <= '0;
      wd        <= '0;
      cnt       <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
    end else begin
      err_q <= cmd_bad | (wd_hit & ~job_end);
      if (cmd_acc) begin
        sel       <= iCTL_SEL;
        in_last   <= 1'b0;
        out_last  <= 1'b0;
        eng_done  <= 1'b0;
        in_beats  <= '0;
        out_beats <= '0;
      end else begin
        if (in_hs) begin
          if (iRm_Tlast) in_last <= 1'b1;
          if (in_beats != 16'hFFFF) in_beats <= in_beats + 16'd1;
        end
        if (pop) begin
          if (oWs_Tlast) out_last <= 1'b1;
          if (out_beats != 16'hFFFF) out_beats <= out_beats + 16'd1;
        end
        if (run & sel_done) eng_done <= 1'b1;
      end
      if (!run || activity) wd <= '0;
      else                  wd <= wd + WDW'(1);
      if (wd_hit) begin
        cnt    <= '0;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
      end else begin
        if (push) wr_ptr <= ~wr_ptr;
        if (pop)  rd_ptr <= ~rd_ptr;
        case ({push, pop})
          2'b10:   cnt <= cnt + 2'd1;
          2'b01:   cnt <= cnt - 2'd1;
          default: cnt <= cnt;
        endcase
      end
    end
  end

  // Payload storage carries no reset; occupancy alone decides validity.
  always_ff @(posedge iSYS_CLK) begin
    if (push) begin
      skid_data[wr_ptr] <= em_data;
      skid_last[wr_ptr] <= em_last;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mdl_bdy_xbar.sv
`default_nettype none
// ============================================================================
// Module   : tb_mdl_bdy_xbar
// Purpose  : Directed self-checking bench for mdl_bdy_xbar (4 engines,
//            16-bit data, 3-bit select, watchdog limit 16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mdl_bdy_xbar;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_valid;
  logic [2:0]  sel;
  logic        busy, done, err;
  logic [15:0] inbeats, outbeats;
  logic        rm_tvalid, rm_tready, rm_tlast;
  logic [15:0] rm_tdata;
  logic [3:0]  eng_start, eng_done;
  logic [3:0]  es_tvalid, es_tready;
  logic [15:0] es_tdata;
  logic        es_tlast;
  logic [3:0]  em_tvalid, em_tready, em_tlast;
  logic [63:0] em_tdata;
  logic        ws_tvalid, ws_tready, ws_tlast;
  logic [15:0] ws_tdata;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0, err_cnt = 0, start_cnt = 0;
  int last_pops = 0, last_pops_at_cmd = 0;
  logic [16:0] exp_q [$];

  always #5 clk = ~clk;

  mdl_bdy_xbar #(
    .PRM_DAXI(16), .PRM_NENG(4), .PRM_SELW(3), .PRM_TOUT(16)
  ) dut (
    .iSYS_CLK(clk), .iSYS_RST(rst_n),
    .iCTL_CMD_VALID(cmd_valid), .iCTL_SEL(sel),
    .oCTL_BUSY(busy), .oCTL_DONE(done), .oCTL_ERR(err),
    .oCTL_INBEATS(inbeats), .oCTL_OUTBEATS(outbeats),
    .iRm_Tvalid(rm_tvalid), .oRm_Tready(rm_tready),
    .iRm_Tdata(rm_tdata), .iRm_Tlast(rm_tlast),
    .oENG_START(eng_start), .iENG_DONE(eng_done),
    .oEs_Tvalid(es_tvalid), .iEs_Tready(es_tready),
    .oEs_Tdata(es_tdata), .oEs_Tlast(es_tlast),
    .iEm_Tvalid(em_tvalid), .oEm_Tready(em_tready),
    .iEm_Tdata(em_tdata), .iEm_Tlast(em_tlast),
    .oWs_Tvalid(ws_tvalid), .iWs_Tready(ws_tready),
    .oWs_Tdata(ws_tdata), .oWs_Tlast(ws_tlast)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Scoreboard: engine beats accepted into the skid are queued, every write
  // side pop must match the oldest queued beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (ws_tvalid && ws_tready) begin
        if (exp_q.size() == 0) begin
          chk("pop_extra", 64'd1, 64'd0);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          chk("ws_data", {48'd0, ws_tdata}, {48'd0, e[15:0]});
          chk("ws_last", {63'd0, ws_tlast}, {63'd0, e[16]});
          if (ws_tlast) last_pops++;
        end
      end
      for (int k = 0; k < 4; k++) begin
        if (em_tvalid[k] && em_tready[k]) exp_q.push_back({em_tlast[k], em_tdata[k*16 +: 16]});
      end
      if (done) begin
        chk("done_skid_empty", {63'd0, exp_q.size() == 0}, 64'd1);
        chk("done_after_last", {63'd0, last_pops > last_pops_at_cmd}, 64'd1);
        done_cnt++;
      end
      if (err) err_cnt++;
      if (eng_start != 4'd0) start_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic cmd(input logic [2:0] s);
    cmd_valid = 1'b1;
    sel = s;
    last_pops_at_cmd = last_pops;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic rm_send(input logic [15:0] d, input logic l, input logic [2:0] s);
    logic ok;
    ok = 1'b0;
    rm_tvalid = 1'b1;
    rm_tdata  = d;
    rm_tlast  = l;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (rm_tready) begin
        chk("es_valid", {60'd0, es_tvalid}, 64'd1 << s);
        chk("es_data", {47'd0, es_tlast, es_tdata}, {47'd0, l, d});
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (!ok) chk("rm_timeout", 64'd0, 64'd1);
    rm_tvalid = 1'b0;
  endtask

  task automatic eng_send(input logic [2:0] s, input logic [15:0] d, input logic l);
    logic ok;
    ok = 1'b0;
    em_tvalid = 4'b0001 << s;
    em_tdata[s*16 +: 16] = d;
    em_tlast = {4{l}};
    for (int i = 0; i < 40; i++) begin
      #1;
      if (em_tready[s]) begin
        ok = 1'b1;
        tick();
        break;
      end
      tick();
    end
    if (!ok) chk("em_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_done();
    logic found;
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (done) begin
        found = 1'b1;
        break;
      end
      tick();
    end
    chk("done_seen", {63'd0, found}, 64'd1);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; cmd_valid = 1'b0; sel = 3'd0;
    rm_tvalid = 1'b0; rm_tdata = 16'd0; rm_tlast = 1'b0;
    eng_done = 4'd0; es_tready = 4'd0;
    em_tvalid = 4'd0; em_tdata = 64'd0; em_tlast = 4'd0;
    ws_tready = 1'b0;

    // Reset state
    tick(); tick(); tick();
    #1;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_done_err", {62'd0, done, err}, 64'd0);
    chk("rst_streams", {60'd0, rm_tready, ws_tvalid, ws_tlast, 1'b0}, 64'd0);
    chk("rst_eng", {52'd0, eng_start, es_tvalid, em_tready}, 64'd0);
    chk("rst_beats", {32'd0, inbeats, outbeats}, 64'd0);
    rst_n = 1'b1;
    tick();

    // Full job on engine 2, 8 beats each way
    es_tready = 4'b0100;
    cmd(3'd2);
    #1;
    chk("start_pulse", {60'd0, eng_start}, 64'h4);
    chk("busy_start", {63'd0, busy}, 64'd1);
    tick();
    #1;
    chk("start_gone", {60'd0, eng_start}, 64'd0);
    for (int i = 0; i < 8; i++) rm_send(16'hA000 + 16'(i), i == 7, 3'd2);
    rm_tvalid = 1'b1;
    #1;
    chk("in_last_block", {59'd0, rm_tready, es_tvalid}, 64'd0);
    rm_tvalid = 1'b0;
    ws_tready = 1'b1;
    for (int j = 0; j < 8; j++) eng_send(3'd2, 16'hB000 + 16'(j), j == 7);
    em_tvalid = 4'd0;
    eng_done = 4'b0100;
    tick();
    eng_done = 4'd0;
    wait_done();
    tick();
    #1;
    chk("a_inbeats", {48'd0, inbeats}, 64'd8);
    chk("a_outbeats", {48'd0, outbeats}, 64'd8);
    chk("a_done_cnt", 64'(done_cnt), 64'd1);
    chk("a_start_cnt", 64'(start_cnt), 64'd1);
    chk("a_idle", {63'd0, busy}, 64'd0);

    // Out-of-range select
    cmd(3'd5);
    #1;
    chk("bad_sel_err", {63'd0, err}, 64'd1);
    chk("bad_sel_busy", {63'd0, busy}, 64'd0);
    tick();
    #1;
    chk("bad_sel_err_gone", {62'd0, err, busy}, 64'd0);

    // Write side stall with early engine done on engine 1
    es_tready = 4'b0010;
    ws_tready = 1'b0;
    cmd(3'd1);
    tick();
    rm_send(16'h00C0, 1'b1, 3'd1);
    eng_send(3'd1, 16'hD000, 1'b0);
    eng_send(3'd1, 16'hD001, 1'b0);
    em_tvalid = 4'b0010;
    em_tdata[31:16] = 16'hD002;
    em_tlast = 4'd0;
    eng_done = 4'b0010;
    #1;
    chk("full_em_ready", {60'd0, em_tready}, 64'd0);
    chk("full_ws_valid", {63'd0, ws_tvalid}, 64'd1);
    tick();
    eng_done = 4'd0;
    cmd(3'd7);
    for (int i = 0; i < 8; i++) tick();
    #1;
    chk("stall_em_ready", {60'd0, em_tready}, 64'd0);
    chk("stall_no_done", {62'd0, done, busy}, 64'd1);
    chk("run_cmd_no_err", 64'(err_cnt), 64'd1);
    ws_tready = 1'b1;
    eng_send(3'd1, 16'hD002, 1'b0);
    eng_send(3'd1, 16'hD003, 1'b1);
    em_tvalid = 4'd0;
    wait_done();
    tick();
    #1;
    chk("c_outbeats", {48'd0, outbeats}, 64'd4);
    chk("c_inbeats", {48'd0, inbeats}, 64'd1);
    chk("c_done_cnt", 64'(done_cnt), 64'd2);

    // Watchdog on a stalled engine 0
    es_tready = 4'b0001;
    cmd(3'd0);
    tick();
    rm_send(16'h00E0, 1'b1, 3'd0);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      #1;
      if (err) begin
        n = i;
        break;
      end
    end
    chk("wd_latency", 64'(n), 64'd16);
    chk("wd_idle", {63'd0, busy}, 64'd0);
    tick();
    #1;
    chk("wd_err_pulse", {63'd0, err}, 64'd0);
    chk("wd_no_done", 64'(done_cnt), 64'd2);

    // Reset mid-job with one beat held in the skid, then a clean job
    es_tready = 4'b1000;
    ws_tready = 1'b0;
    cmd(3'd3);
    tick();
    eng_send(3'd3, 16'hF000, 1'b1);
    em_tvalid = 4'd0;
    #1;
    chk("skid_one", {63'd0, ws_tvalid}, 64'd1);
    rst_n = 1'b0;
    tick();
    #1;
    chk("mid_rst_busy", {61'd0, busy, done, err}, 64'd0);
    chk("mid_rst_streams", {61'd0, rm_tready, ws_tvalid, ws_tlast}, 64'd0);
    chk("mid_rst_eng", {52'd0, eng_start, es_tvalid, em_tready}, 64'd0);
    chk("mid_rst_beats", {32'd0, inbeats, outbeats}, 64'd0);
    tick();
    rst_n = 1'b1;
    ws_tready = 1'b1;
    tick();
    cmd(3'd3);
    tick();
    rm_send(16'h0011, 1'b0, 3'd3);
    rm_send(16'h0012, 1'b1, 3'd3);
    eng_send(3'd3, 16'hF100, 1'b0);
    eng_send(3'd3, 16'hF101, 1'b1);
    em_tvalid = 4'd0;
    eng_done = 4'b1000;
    tick();
    eng_done = 4'd0;
    wait_done();
    tick();
    #1;
    chk("e_inbeats", {48'd0, inbeats}, 64'd2);
    chk("e_outbeats", {48'd0, outbeats}, 64'd2);
    chk("e_done_cnt", 64'(done_cnt), 64'd3);
    chk("e_err_cnt", 64'(err_cnt), 64'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
